// File: rtl/com_out_fifo.sv
// rtl/com_out_fifo.sv - CPU communication output FIFO with valid/ready drain and overflow status
// Captures COM-qualified load words and drains them to an external consumer.
module com_out_fifo #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = 6,
  parameter int HOLD_LAST   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemtoReg,
  input  logic                       COM,
  input  logic [DATA_W-1:0]          ReadData,
  input  logic                       OutReady,
  output logic                       OutValid,
  output logic [DATA_W-1:0]          ReadDataOut,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Full,
  output logic                       AlmostFull,
  output logic                       Overflow,
  input  logic                       ClearOverflow,
  output logic [7:0]                 DropCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic push_req, push, pop, full, drop;

  always_comb begin
    push_req   = MemtoReg & COM;
    full       = (count_q == DEPTH_C);
    pop        = (count_q != '0) & OutReady;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push       = push_req & (~full | pop);
    drop       = push_req & full & ~pop;

    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    last_d     = pop  ? mem_q[rd_ptr_q]   : last_q;

    count_d    = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);

    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (ClearOverflow) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      ovf_d      = 1'b1;
      drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_q     <= last_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is left uninitialised; Count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ReadData;
  end

  always_comb begin
    OutValid   = (count_q != '0);
    Count      = count_q;
    Full       = full;
    AlmostFull = (count_q >= AFULL_C);
    Overflow   = ovf_q;
    DropCount  = drop_cnt_q;
    if (count_q != '0)       ReadDataOut = mem_q[rd_ptr_q];
    else if (HOLD_LAST != 0) ReadDataOut = last_q;
    else                     ReadDataOut = '0;
  end

endmodule
